// File: rtl/present_ctrl_pkg.sv
// Shared constants and types for the PRESENT S-box layer controller.
// Beat-sliced share type, FSM state enum and the beat tag that rides alongside the core.
package present_ctrl_pkg;

  localparam int unsigned STATE_W   = 64;
  localparam int unsigned BEAT_W    = 8;
  localparam int unsigned NBEATS    = STATE_W / BEAT_W;
  localparam int unsigned RND_W     = 90;
  localparam int unsigned SBOX_LAT  = 3;
  localparam int unsigned IDX_W     = $clog2(NBEATS);
  // Input register stage plus the core's own pipeline.
  localparam int unsigned TAG_DEPTH = SBOX_LAT + 1;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NBEATS - 1);

  typedef logic [NBEATS-1:0][BEAT_W-1:0] beats_t;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } ctrl_state_e;

  typedef struct packed {
    logic             v;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/present_ctrl_tag_pipe.sv
// Shift register of beat tags, aligned with the S-box core latency so that each core
// result can be routed to its byte slot. Bubbles travel as tags with v=0.
module present_ctrl_tag_pipe
  import present_ctrl_pkg::*;
#(
  parameter int unsigned Depth = TAG_DEPTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t [Depth-1:0] pipe_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[Depth-2:0], tag_i};
    end
  end

  assign tag_o = pipe_q[Depth-1];

endmodule

// File: rtl/present_sbox_layer_ctrl.sv
// Sequences a 3-share PRESENT S-box layer through a masked two-S-box core, one byte per share
// per beat. Optional build macro PRESENT_CTRL_BUBBLE_ZERO_EN zeroes core inputs when not issuing.
module present_sbox_layer_ctrl
  import present_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [STATE_W-1:0] in_s1_i,
  input  logic [STATE_W-1:0] in_s2_i,
  input  logic [STATE_W-1:0] in_s3_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STATE_W-1:0] out_s1_o,
  output logic [STATE_W-1:0] out_s2_o,
  output logic [STATE_W-1:0] out_s3_o,
  input  logic               rnd_valid_i,
  output logic               rnd_ready_o,
  input  logic [RND_W-1:0]   rnd_i,
  output logic [BEAT_W-1:0]  core_in1_o,
  output logic [BEAT_W-1:0]  core_in2_o,
  output logic [BEAT_W-1:0]  core_in3_o,
  output logic [RND_W-1:0]   core_r_o,
  input  logic [BEAT_W-1:0]  core_out1_i,
  input  logic [BEAT_W-1:0]  core_out2_i,
  input  logic [BEAT_W-1:0]  core_out3_i
);

  ctrl_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic ready_q;

  beats_t s1_q, s2_q, s3_q;
  beats_t out_s1_q, out_s2_q, out_s3_q;
  logic [BEAT_W-1:0] core_in1_q, core_in2_q, core_in3_q;
  logic [RND_W-1:0]  core_r_q;

  logic accept, issue, last_exit;
  tag_t tag_in, tag_out;

  assign in_ready_o  = ready_q && (state_q == StIdle);
  assign rnd_ready_o = (state_q == StFeed);
  assign out_valid_o = (state_q == StDone);

  assign accept    = in_valid_i && in_ready_o;
  assign issue     = (state_q == StFeed) && rnd_valid_i;
  assign last_exit = tag_out.v && (tag_out.idx == LastIdx);

  assign tag_in.v   = issue;
  assign tag_in.idx = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StFeed;
          cnt_d   = '0;
        end
      end
      StFeed: begin
        if (issue) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (last_exit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else if (accept) begin
      s1_q <= in_s1_i;
      s2_q <= in_s2_i;
      s3_q <= in_s3_i;
    end
  end

  // Each share goes to the core on its own wire; shares are never combined here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      core_in1_q <= '0;
      core_in2_q <= '0;
      core_in3_q <= '0;
      core_r_q   <= '0;
    end else if (issue) begin
      core_in1_q <= s1_q[cnt_q];
      core_in2_q <= s2_q[cnt_q];
      core_in3_q <= s3_q[cnt_q];
      core_r_q   <= rnd_i;
    end
`ifdef PRESENT_CTRL_BUBBLE_ZERO_EN
    else begin
      core_in1_q <= '0;
      core_in2_q <= '0;
      core_in3_q <= '0;
      core_r_q   <= '0;
    end
`endif
  end

  present_ctrl_tag_pipe #(
    .Depth(TAG_DEPTH)
  ) u_tag_pipe (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_s1_q <= '0;
      out_s2_q <= '0;
      out_s3_q <= '0;
    end else if (tag_out.v) begin
      out_s1_q[tag_out.idx] <= core_out1_i;
      out_s2_q[tag_out.idx] <= core_out2_i;
      out_s3_q[tag_out.idx] <= core_out3_i;
    end
  end

  assign out_s1_o   = out_s1_q;
  assign out_s2_o   = out_s2_q;
  assign out_s3_o   = out_s3_q;
  assign core_in1_o = core_in1_q;
  assign core_in2_o = core_in2_q;
  assign core_in3_o = core_in3_q;
  assign core_r_o   = core_r_q;

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Directed bench for present_sbox_layer_ctrl with a behavioural 3-cycle masked S-box core.
module tb_present_sbox_layer_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_s1 = '0, in_s2 = '0, in_s3 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_s1, out_s2, out_s3;
  logic        rnd_valid = 1'b1;
  logic        rnd_ready;
  logic [89:0] rnd = '0;
  logic [7:0]  core_in1, core_in2, core_in3;
  logic [89:0] core_r;
  logic [7:0]  core_out1, core_out2, core_out3;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  present_sbox_layer_ctrl dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_s1_i    (in_s1),
    .in_s2_i    (in_s2),
    .in_s3_i    (in_s3),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_s1_o   (out_s1),
    .out_s2_o   (out_s2),
    .out_s3_o   (out_s3),
    .rnd_valid_i(rnd_valid),
    .rnd_ready_o(rnd_ready),
    .rnd_i      (rnd),
    .core_in1_o (core_in1),
    .core_in2_o (core_in2),
    .core_in3_o (core_in3),
    .core_r_o   (core_r),
    .core_out1_i(core_out1),
    .core_out2_i(core_out2),
    .core_out3_i(core_out3)
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  // Core model: out2/out3 are fresh masks from r, out1 completes the sharing.
  function automatic logic [23:0] core_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [89:0] r);
    logic [7:0] x, y;
    x = a ^ b ^ c;
    y = {sb(x[7:4]), sb(x[3:0])};
    return {r[23:16], r[15:8], y ^ r[15:8] ^ r[23:16]};
  endfunction

  logic [2:0][23:0] cp;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cp <= '0;
    end else begin
      cp[0] <= core_f(core_in1, core_in2, core_in3, core_r);
      cp[1] <= cp[0];
      cp[2] <= cp[1];
    end
  end
  assign core_out1 = cp[2][7:0];
  assign core_out2 = cp[2][15:8];
  assign core_out3 = cp[2][23:16];

  typedef struct {
    logic [63:0] st;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [7:0]  mask;     // beat indices that get one rnd_valid bubble first
    int          hold;     // cycles out_ready stays low in DONE
    logic [63:0] exp_sub;
    int          exp_lat;  // cycles from handshake cycle (inclusive) to first out_valid cycle
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_txn(input vec_t v);
    int n;
    @(negedge clk_i);
    in_valid = 1'b1;
    in_s1 = v.st ^ v.s2 ^ v.s3;
    in_s2 = v.s2;
    in_s3 = v.s3;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk_i);
  endtask

  // Called right after the accepting edge; optionally aborts with reset at a given beat.
  task automatic feed_txn(input vec_t v, input int abort_beat, input bit next_valid,
                          input vec_t nv);
    logic [89:0] rw[8];
    logic [7:0]  bub;
    logic [63:0] exp2, snap;
    int b, hs, lat;
    bit stable;
    b = 0; hs = 0; lat = -1; bub = '0; exp2 = '0;
    for (int n = 0; n < 60 && lat < 0; n++) begin
      @(negedge clk_i);
      if (n == 0) begin
        in_valid = 1'b0;
        chk("busy_in_ready", 64'(in_ready), 64'd0);
      end
      if (abort_beat < 8 && b == abort_beat) begin
        rst_ni = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_rnd_ready", 64'(rnd_ready), 64'd0);
        chk("abort_out_s1", out_s1, 64'd0);
        chk("abort_core_in1", 64'(core_in1), 64'd0);
        chk("abort_core_r", 64'(core_r != '0), 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        return;
      end
      if (out_valid) begin
        lat = n + 1;
      end else if (rnd_ready) begin
        if (b < 8 && v.mask[b] && !bub[b]) begin
          rnd_valid = 1'b0;
          bub[b] = 1'b1;
        end else begin
          rnd_valid = 1'b1;
          rnd = {$urandom, $urandom, $urandom};
          if (b < 8) rw[b] = rnd;
          b++;
          hs++;
        end
      end else begin
        rnd_valid = 1'b1;
      end
    end
    for (int k = 0; k < 8; k++) exp2[8*k +: 8] = rw[k][15:8];
    chk("latency", 64'(lat), 64'(v.exp_lat));
    chk("rnd_handshakes", 64'(hs), 64'd8);
    chk("xor_result", out_s1 ^ out_s2 ^ out_s3, v.exp_sub);
    chk("share2_rnd_slots", out_s2, exp2);
    snap = out_s1;
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk_i);
      if (!out_valid || in_ready || out_s1 !== snap) stable = 1'b0;
    end
    if (v.hold > 0) chk("hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    if (next_valid) begin
      in_valid = 1'b1;
      in_s1 = nv.st ^ nv.s2 ^ nv.s3;
      in_s2 = nv.s2;
      in_s3 = nv.s3;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    out_ready = 1'b0;
    chk("out_taken", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{64'h0123456789ABCDEF, 64'd0, 64'd0, 8'h00, 0, 64'hC56B90AD3EF84712, 13};
    vecs[1] = '{64'h0123456789ABCDEF, {$urandom, $urandom}, {$urandom, $urandom}, 8'h00, 2,
                64'hC56B90AD3EF84712, 13};
    vecs[2] = '{64'h0123456789ABCDEF, {$urandom, $urandom}, {$urandom, $urandom}, 8'b0010_0100,
                0, 64'hC56B90AD3EF84712, 15};
    vecs[3] = '{64'hFEDCBA9876543210, {$urandom, $urandom}, {$urandom, $urandom}, 8'b1000_0001,
                10, 64'h21748FE3DA09B65C, 15};
    vecs[4] = '{64'h0, {$urandom, $urandom}, {$urandom, $urandom}, 8'h00, 1,
                64'hCCCCCCCCCCCCCCCC, 13};

    #1 rst_ni = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rnd_ready", 64'(rnd_ready), 64'd0);
    chk("rst_out_s1", out_s1, 64'd0);
    chk("rst_core_in2", 64'(core_in2), 64'd0);
    chk("rst_core_r", 64'(core_r != '0), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 5; i++) begin
      start_txn(vecs[i]);
      feed_txn(vecs[i], 8, 1'b0, vecs[i]);
    end

    // Reset during beat 4, then a clean restart.
    start_txn(vecs[1]);
    feed_txn(vecs[1], 4, 1'b0, vecs[1]);
    chk("post_abort_out_valid", 64'(out_valid), 64'd0);
    start_txn(vecs[1]);
    feed_txn(vecs[1], 8, 1'b0, vecs[1]);

    // Back-to-back: next state offered with out_ready, accepted on the following edge.
    start_txn(vecs[3]);
    feed_txn(vecs[3], 8, 1'b1, vecs[2]);
    @(posedge clk_i);
    feed_txn(vecs[2], 8, 1'b0, vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
